// File: rtl/rgb_keystream_cipher.sv
// rgb_keystream_cipher
//   Consumer end of an RGB keystream: key triples {R,G,B} are captured on each
//   key_ready strobe into a small FIFO. One key triple is XORed into each pixel
//   of a framed valid/ready pixel stream. XOR is its own inverse, so the same
//   block encrypts and decrypts.
//
//   Optional feature macro: CIPHER_CHAIN_EN
//     When defined, every pixel is also XORed with a 24-bit chaining register C
//     (cleared at start). Encrypt feeds C from the output word, decrypt feeds C
//     from the input word, so a decrypt pass undoes an encrypt pass.
//     When undefined, the decrypt input is ignored and no chain register exists.
module rgb_keystream_cipher #(
  parameter int KEY_DEPTH = 8,
  parameter int FRAME_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_ready,
  input  logic [7:0]                   key_r,
  input  logic [7:0]                   key_g,
  input  logic [7:0]                   key_b,
  input  logic                         start,
  input  logic [FRAME_W-1:0]           frame_len,
  input  logic                         decrypt,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [7:0]                   pix_r,
  input  logic [7:0]                   pix_g,
  input  logic [7:0]                   pix_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_r,
  output logic [7:0]                   out_g,
  output logic [7:0]                   out_b,
  output logic                         busy,
  output logic                         done,
  output logic                         key_overflow,
  output logic [$clog2(KEY_DEPTH):0]   key_level
);

  localparam int PTR_W = $clog2(KEY_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Three-way XOR of pixel, key and chain words.
  function automatic logic [23:0] cipher_word(input logic [23:0] pix,
                                              input logic [23:0] key,
                                              input logic [23:0] chain);
    return pix ^ key ^ chain;
  endfunction

  // Key FIFO storage and pointers
  logic [23:0]       key_mem_q [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [23:0]       key_word;

  // Frame control
  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] remaining_q, remaining_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  // Output register
  logic               out_valid_q, out_valid_d;
  logic [23:0]        out_data_q, out_data_d;

  // Datapath
  logic [23:0]        pix_word;
  logic [23:0]        chain_word;
  logic [23:0]        result_word;
  logic               fire;
  logic               out_free;

`ifdef CIPHER_CHAIN_EN
  logic [23:0]        chain_q, chain_d;
  logic               decrypt_q, decrypt_d;
  assign chain_word = chain_q;
`else
  logic               unused_decrypt;
  assign unused_decrypt = decrypt;
  assign chain_word     = 24'd0;
`endif

  assign fifo_full   = (level_q == LVL_W'(KEY_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign key_word    = key_mem_q[rd_ptr_q];
  assign pix_word    = {pix_r, pix_g, pix_b};
  assign result_word = cipher_word(pix_word, key_word, chain_word);

  // The output slot can take a new pixel when it is empty or draining this cycle.
  assign out_free  = !out_valid_q || out_ready;
  assign pix_ready = (state_q == S_RUN) && out_free && !fifo_empty;
  assign fire      = pix_valid && pix_ready;
  assign pop       = fire;
  // A full FIFO still accepts a key when a pop frees a slot in the same cycle.
  assign push      = key_ready && (!fifo_full || pop);

  // Next-state logic for FIFO bookkeeping, frame FSM and output register
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
`ifdef CIPHER_CHAIN_EN
    chain_d     = chain_q;
    decrypt_d   = decrypt_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (frame_len != '0) begin
            remaining_d = frame_len;
            state_d     = S_RUN;
`ifdef CIPHER_CHAIN_EN
            chain_d     = 24'd0;
            decrypt_d   = decrypt;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          out_data_d  = result_word;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - FRAME_W'(1);
`ifdef CIPHER_CHAIN_EN
          chain_d     = decrypt_q ? pix_word : result_word;
`endif
          if (remaining_q == FRAME_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Hold off the done pulse until the final output word has been taken.
        if (out_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A dropped key outranks a same-cycle clear so the loss is never hidden.
    if (key_ready && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State and control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 24'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
`ifdef CIPHER_CHAIN_EN
      chain_q     <= 24'd0;
      decrypt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
`ifdef CIPHER_CHAIN_EN
      chain_q     <= chain_d;
      decrypt_q   <= decrypt_d;
`endif
    end
  end

  // Key storage write port; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      key_mem_q[wr_ptr_q] <= {key_r, key_g, key_b};
    end
  end

  assign out_valid    = out_valid_q;
  assign out_r        = out_data_q[23:16];
  assign out_g        = out_data_q[15:8];
  assign out_b        = out_data_q[7:0];
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign key_overflow = overflow_q;
  assign key_level    = level_q;

endmodule

// File: tb/tb_rgb_keystream_cipher.sv
// Directed testbench for rgb_keystream_cipher (KEY_DEPTH=8, FRAME_W=16).
// Expected values are hand-computed; CIPHER_CHAIN_EN selects the chained
// expectations where the optional feature changes the outputs.
module tb_rgb_keystream_cipher;

  logic        clk;
  logic        rst;
  logic        key_ready;
  logic [7:0]  key_r, key_g, key_b;
  logic        start;
  logic [15:0] frame_len;
  logic        decrypt;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b;
  logic        busy;
  logic        done;
  logic        key_overflow;
  logic [3:0]  key_level;

  int checks;
  int errors;

  rgb_keystream_cipher #(.KEY_DEPTH(8), .FRAME_W(16)) dut (
    .clk(clk), .rst(rst), .key_ready(key_ready),
    .key_r(key_r), .key_g(key_g), .key_b(key_b),
    .start(start), .frame_len(frame_len), .decrypt(decrypt),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .busy(busy), .done(done), .key_overflow(key_overflow), .key_level(key_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    key_ready = 1'b1; key_r = r; key_g = g; key_b = b;
    tick();
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({pix_ready, out_valid, out_r, out_g, out_b, busy, done, key_overflow, key_level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pr=%b ov=%b out=%h%h%h busy=%b done=%b ovf=%b lvl=%0d, want all 0",
               pix_ready, out_valid, out_r, out_g, out_b, busy, done, key_overflow, key_level);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push_key(8'h11, 8'h22, 8'h33);
    checks++;
    if (key_level !== 4'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", key_level); end
    start = 1'b1; frame_len = 16'd1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    pix_valid = 1'b1; pix_r = 8'hAA; pix_g = 8'hBB; pix_b = 8'hCC; out_ready = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL basic_pix_ready: got %b want 1", pix_ready); end
    tick(); pix_valid = 1'b0;
    checks++;
    if ({out_valid, out_r, out_g, out_b} !== {1'b1, 24'hBB99FF}) begin
      errors++; $display("FAIL basic_out: got v=%b %h%h%h want v=1 BB99FF", out_valid, out_r, out_g, out_b);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", done); end
    tick();
    checks++;
    if ({done, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b ov=%b busy=%b want 1 0 0", done, out_valid, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_done_clear: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_key_wait();
    start = 1'b1; frame_len = 16'd2; tick(); start = 1'b0;
    pix_valid = 1'b1; pix_r = 8'h01; pix_g = 8'h02; pix_b = 8'h03; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL wait_empty: got pix_ready=%b want 0", pix_ready); end
    key_ready = 1'b1; key_r = 8'h10; key_g = 8'h20; key_b = 8'h30;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL wait_no_bypass: got pix_ready=%b want 0", pix_ready); end
    tick(); key_ready = 1'b0; #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL wait_key_arrived: got pix_ready=%b want 1", pix_ready); end
    tick();
    checks++;
    if ({out_valid, out_r, out_g, out_b} !== {1'b1, 24'h112233}) begin
      errors++; $display("FAIL wait_out1: got v=%b %h%h%h want v=1 112233", out_valid, out_r, out_g, out_b);
    end
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL wait_empty2: got pix_ready=%b want 0", pix_ready); end
    pix_r = 8'hF0; pix_g = 8'hF0; pix_b = 8'hF0;
    push_key(8'h0F, 8'h0F, 8'h0F);
    tick(); pix_valid = 1'b0;
    checks++;
`ifdef CIPHER_CHAIN_EN
    if ({out_r, out_g, out_b} !== 24'hEEDDCC) begin
      errors++; $display("FAIL wait_out2: got %h%h%h want EEDDCC", out_r, out_g, out_b);
    end
`else
    if ({out_r, out_g, out_b} !== 24'hFFFFFF) begin
      errors++; $display("FAIL wait_out2: got %h%h%h want FFFFFF", out_r, out_g, out_b);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL wait_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_overflow();
    logic [23:0] exp_q [8];
    logic [23:0] c;
    int idx;
    bit seen_done;
    c = 24'd0;
    for (int i = 0; i < 9; i++) begin
      push_key(8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3));
    end
    for (int i = 0; i < 8; i++) begin
`ifdef CIPHER_CHAIN_EN
      exp_q[i] = {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)} ^ c;
      c = exp_q[i];
`else
      exp_q[i] = {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)};
`endif
    end
    checks++;
    if ({key_level, key_overflow} !== {4'd8, 1'b1}) begin
      errors++; $display("FAIL ovf_set: got lvl=%0d ovf=%b want 8 1", key_level, key_overflow);
    end
    start = 1'b1; frame_len = 16'd8; decrypt = 1'b0; tick(); start = 1'b0;
    checks++;
    if (key_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", key_overflow); end
    pix_valid = 1'b1; pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00; out_ready = 1'b1;
    idx = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      tick();
      if (out_valid && idx < 8) begin
        checks++;
        if ({out_r, out_g, out_b} !== exp_q[idx]) begin
          errors++; $display("FAIL ovf_drain[%0d]: got %h%h%h want %h", idx, out_r, out_g, out_b, exp_q[idx]);
        end
        idx++;
      end
      if (done) seen_done = 1'b1;
    end
    pix_valid = 1'b0;
    checks++;
    if ({seen_done, idx[3:0], key_level} !== {1'b1, 4'd8, 4'd0}) begin
      errors++; $display("FAIL ovf_drain_end: got done=%b n=%0d lvl=%0d want 1 8 0", seen_done, idx, key_level);
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    push_key(8'hA1, 8'hB2, 8'hC3);
    push_key(8'h5A, 8'h5A, 8'h5A);
    start = 1'b1; frame_len = 16'd2; tick(); start = 1'b0;
    pix_valid = 1'b1; pix_r = 8'h01; pix_g = 8'h02; pix_b = 8'h03;
    tick();
    pix_r = 8'hFF; pix_g = 8'h00; pix_b = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_r, out_g, out_b, pix_ready, key_level} !== {1'b1, 24'hA0B0C0, 1'b0, 4'd1}) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b %h%h%h pr=%b lvl=%0d want v=1 A0B0C0 pr=0 lvl=1",
                           k, out_valid, out_r, out_g, out_b, pix_ready, key_level);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got pix_ready=%b want 1", pix_ready); end
    tick(); pix_valid = 1'b0;
    checks++;
`ifdef CIPHER_CHAIN_EN
    if ({out_valid, out_r, out_g, out_b} !== {1'b1, 24'h05EA95}) begin
      errors++; $display("FAIL stall_out2: got v=%b %h%h%h want v=1 05EA95", out_valid, out_r, out_g, out_b);
    end
`else
    if ({out_valid, out_r, out_g, out_b} !== {1'b1, 24'hA55A55}) begin
      errors++; $display("FAIL stall_out2: got v=%b %h%h%h want v=1 A55A55", out_valid, out_r, out_g, out_b);
    end
`endif
    tick();
    checks++;
    if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL stall_done: got done=%b ov=%b want 1 0", done, out_valid); end
    tick();
  endtask

  // Runs a two-pixel frame with red-only keys and pixels, returning both red outputs.
  task automatic run_frame2(input logic d, input logic [7:0] k0, input logic [7:0] k1,
                            input logic [7:0] p0, input logic [7:0] p1,
                            output logic [7:0] o0, output logic [7:0] o1);
    push_key(k0, 8'h00, 8'h00);
    push_key(k1, 8'h00, 8'h00);
    out_ready = 1'b1;
    start = 1'b1; frame_len = 16'd2; decrypt = d; tick(); start = 1'b0; decrypt = 1'b0;
    pix_valid = 1'b1; pix_r = p0; pix_g = 8'h00; pix_b = 8'h00;
    tick(); o0 = out_r;
    pix_r = p1;
    tick(); o1 = out_r;
    pix_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_chain();
    logic [7:0] o0, o1;
    run_frame2(1'b0, 8'h01, 8'h02, 8'h10, 8'h10, o0, o1);
    checks++;
`ifdef CIPHER_CHAIN_EN
    if ({o0, o1} !== 16'h1103) begin errors++; $display("FAIL chain_encrypt: got %h %h want 11 03", o0, o1); end
`else
    if ({o0, o1} !== 16'h1112) begin errors++; $display("FAIL chain_encrypt: got %h %h want 11 12", o0, o1); end
`endif
    run_frame2(1'b1, 8'h01, 8'h02, 8'h11, 8'h03, o0, o1);
    checks++;
`ifdef CIPHER_CHAIN_EN
    if ({o0, o1} !== 16'h1010) begin errors++; $display("FAIL chain_decrypt: got %h %h want 10 10", o0, o1); end
`else
    if ({o0, o1} !== 16'h1001) begin errors++; $display("FAIL chain_decrypt: got %h %h want 10 01", o0, o1); end
`endif
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    push_key(8'h01, 8'h01, 8'h01);
    push_key(8'h02, 8'h02, 8'h02);
    out_ready = 1'b1;
    start = 1'b1; frame_len = 16'd3; tick(); start = 1'b0;
    pix_valid = 1'b1; pix_r = 8'h55; pix_g = 8'h55; pix_b = 8'h55;
    tick(); pix_valid = 1'b0;
    rst = 1'b1; tick(); tick();
    checks++;
    if ({pix_ready, out_valid, out_r, out_g, out_b, busy, done, key_overflow, key_level} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got pr=%b ov=%b out=%h%h%h busy=%b done=%b ovf=%b lvl=%0d, want all 0",
               pix_ready, out_valid, out_r, out_g, out_b, busy, done, key_overflow, key_level);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrun_no_done: got done/busy activity=%b want 0", saw_done); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; key_ready = 1'b0; key_r = '0; key_g = '0; key_b = '0;
    start = 1'b0; frame_len = '0; decrypt = 1'b0;
    pix_valid = 1'b0; pix_r = '0; pix_g = '0; pix_b = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_key_wait();
    test_overflow();
    test_back_to_back_stall();
    test_chain();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
